// File: rtl/i2s_stereo_dac_transmitter_if.sv
// Sample handshake plus I2S pin bundle for i2s_stereo_dac_transmitter.
// slave is the transmitter's view; master is the producer/DAC side.
interface i2s_stereo_dac_transmitter_if #(
    parameter int unsigned w_sample = 16
);
    logic                       in_valid;
    logic                       in_ready;
    logic signed [w_sample-1:0] in_left;
    logic signed [w_sample-1:0] in_right;
    logic                       mclk;
    logic                       bclk;
    logic                       lrclk;
    logic                       sdata;
    logic                       underrun;

    modport master (
        output in_valid, in_left, in_right,
        input  in_ready, mclk, bclk, lrclk, sdata, underrun
    );

    modport slave (
        input  in_valid, in_left, in_right,
        output in_ready, mclk, bclk, lrclk, sdata, underrun
    );
endinterface

// File: rtl/i2s_stereo_dac_transmitter.sv
// I2S master transmitter for a stereo DAC: derives MCLK/BCLK/LRCLK from clk and serialises sample pairs.
// Define I2S_TX_UNDERRUN_REPEAT_EN to replay the last played pair on underrun instead of silence.
module i2s_stereo_dac_transmitter #(
    parameter int unsigned clk_mhz  = 100,
    parameter int unsigned w_sample = 16,
    parameter int unsigned bclk_div = 16
) (
    input logic                         clk,
    input logic                         rst,
    i2s_stereo_dac_transmitter_if.slave bus
);
    if (clk_mhz == 0) begin : g_bad_clk_mhz
        $error("clk_mhz must be non-zero");
    end
    if (w_sample < 8 || w_sample > 31) begin : g_bad_w_sample
        $error("w_sample must be in 8..31");
    end
    if (bclk_div < 4 || (bclk_div % 4) != 0) begin : g_bad_bclk_div
        $error("bclk_div must be a multiple of 4 and at least 4");
    end

    localparam int unsigned   DW       = $clog2(bclk_div);
    localparam int unsigned   Q        = bclk_div / 4;
    localparam logic [DW-1:0] DIV_LAST = DW'(bclk_div - 1);
    localparam logic [DW-1:0] MCLK_T1  = DW'(Q - 1);
    localparam logic [DW-1:0] MCLK_T2  = DW'(2 * Q - 1);
    localparam logic [DW-1:0] MCLK_T3  = DW'(3 * Q - 1);

    typedef enum logic {HOLD_EMPTY, HOLD_FULL} hold_state_t;

    hold_state_t         hold_state;
    hold_state_t         hold_state_next;
    logic [DW-1:0]       div_cnt;
    logic                mclk_armed;
    logic [5:0]          bit_cnt;
    logic [5:0]          bit_next;
    logic [63:0]         shift_frame;
    logic [63:0]         load_frame;
    logic [63:0]         underrun_frame;
    logic [w_sample-1:0] hold_left;
    logic [w_sample-1:0] hold_right;
    logic                div_wrap;
    logic                mclk_edge;
    logic                fall_tick;
    logic                frame_start;
    logic                transfer;

    // Slot layout per half-frame: one idle bit, the sample MSB first, then zero padding to 32 bits.
    function automatic logic [63:0] make_frame(input logic [w_sample-1:0] l,
                                               input logic [w_sample-1:0] r);
        logic [31:0] half_l;
        logic [31:0] half_r;
        half_l = '0;
        half_r = '0;
        half_l[30 -: w_sample] = l;
        half_r[30 -: w_sample] = r;
        return {half_l, half_r};
    endfunction

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    logic [w_sample-1:0] last_left;
    logic [w_sample-1:0] last_right;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_left  <= '0;
            last_right <= '0;
        end else if (frame_start && hold_state == HOLD_FULL) begin
            last_left  <= hold_left;
            last_right <= hold_right;
        end
    end

    always_comb underrun_frame = make_frame(last_left, last_right);
`else
    always_comb underrun_frame = '0;
`endif

    assign bus.in_ready = (hold_state == HOLD_EMPTY) && !rst;

    always_comb begin
        div_wrap    = (div_cnt == DIV_LAST);
        mclk_edge   = (div_cnt == MCLK_T1) || (div_cnt == MCLK_T2) ||
                      (div_cnt == MCLK_T3) || div_wrap;
        fall_tick   = div_wrap && bus.bclk;
        bit_next    = bit_cnt + 6'd1;
        frame_start = fall_tick && (bit_cnt == 6'd63);
        transfer    = bus.in_valid && bus.in_ready;
        load_frame  = (hold_state == HOLD_FULL) ? make_frame(hold_left, hold_right)
                                                : underrun_frame;

        hold_state_next = hold_state;
        case (hold_state)
            HOLD_EMPTY: if (transfer)    hold_state_next = HOLD_FULL;
            HOLD_FULL:  if (frame_start) hold_state_next = HOLD_EMPTY;
            default:                     hold_state_next = HOLD_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) hold_state <= HOLD_EMPTY;
        else     hold_state <= hold_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt      <= '0;
            mclk_armed   <= 1'b0;
            bit_cnt      <= '1;
            shift_frame  <= '0;
            hold_left    <= '0;
            hold_right   <= '0;
            bus.mclk     <= 1'b0;
            bus.bclk     <= 1'b0;
            bus.lrclk    <= 1'b0;
            bus.sdata    <= 1'b0;
            bus.underrun <= 1'b0;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + DW'(1);
            if (div_wrap) bus.bclk <= ~bus.bclk;

            // The first MCLK toggle point after reset is skipped so MCLK rises together with BCLK.
            if (mclk_edge) begin
                mclk_armed <= 1'b1;
                if (mclk_armed) bus.mclk <= ~bus.mclk;
            end

            bus.underrun <= frame_start && (hold_state == HOLD_EMPTY);

            if (transfer) begin
                hold_left  <= bus.in_left;
                hold_right <= bus.in_right;
            end

            if (fall_tick) begin
                bit_cnt   <= bit_next;
                bus.lrclk <= bit_next[5];
                if (frame_start) begin
                    bus.sdata   <= load_frame[63];
                    shift_frame <= {load_frame[62:0], 1'b0};
                end else begin
                    bus.sdata   <= shift_frame[63];
                    shift_frame <= {shift_frame[62:0], 1'b0};
                end
            end
        end
    end
endmodule
